// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus responder: register map, reset values,
// FSM encoding and small register-file helpers.
package rtc_bus_pkg;

  localparam logic [7:0] ADDR_SEG   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HORA  = 8'h23;
  localparam logic [7:0] ADDR_DIA   = 8'h24;
  localparam logic [7:0] ADDR_MES   = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_SEGC  = 8'h41;
  localparam logic [7:0] ADDR_MINC  = 8'h42;
  localparam logic [7:0] ADDR_HORAC = 8'h43;
  localparam logic [7:0] ADDR_CMD   = 8'hF0;

  localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX = 8'h12;

  localparam logic [7:0] RST_SEG   = 8'h00;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HORA  = 8'h12;
  localparam logic [7:0] RST_DIA   = 8'h01;
  localparam logic [7:0] RST_MES   = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;
  localparam logic [7:0] RST_CRONO = 8'h00;
  localparam logic [7:0] RST_ADDR  = 8'hFF;
  localparam logic [7:0] BUS_IDLE  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRDATA,
    ST_RDDATA
  } state_t;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] min;
    logic [7:0] hora;
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] year;
    logic [7:0] segc;
    logic [7:0] minc;
    logic [7:0] horac;
  } rtc_regs_t;

  localparam rtc_regs_t REGS_RST = '{
    seg:   RST_SEG,
    min:   RST_MIN,
    hora:  RST_HORA,
    dia:   RST_DIA,
    mes:   RST_MES,
    year:  RST_YEAR,
    segc:  RST_CRONO,
    minc:  RST_CRONO,
    horac: RST_CRONO
  };

  // Two-digit BCD increment; callers handle the wrap limits themselves.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  function automatic logic [7:0] reg_read(input rtc_regs_t r, input logic [7:0] a);
    case (a)
      ADDR_SEG:   return r.seg;
      ADDR_MIN:   return r.min;
      ADDR_HORA:  return r.hora;
      ADDR_DIA:   return r.dia;
      ADDR_MES:   return r.mes;
      ADDR_YEAR:  return r.year;
      ADDR_SEGC:  return r.segc;
      ADDR_MINC:  return r.minc;
      ADDR_HORAC: return r.horac;
      ADDR_CMD:   return 8'h00;
      default:    return BUS_IDLE;
    endcase
  endfunction

  function automatic rtc_regs_t reg_write(input rtc_regs_t r, input logic [7:0] a,
                                          input logic [7:0] d);
    rtc_regs_t w;
    w = r;
    case (a)
      ADDR_SEG:   w.seg   = d;
      ADDR_MIN:   w.min   = d;
      ADDR_HORA:  w.hora  = d;
      ADDR_DIA:   w.dia   = d;
      ADDR_MES:   w.mes   = d;
      ADDR_YEAR:  w.year  = d;
      ADDR_SEGC:  w.segc  = d;
      ADDR_MINC:  w.minc  = d;
      ADDR_HORAC: w.horac = d;
      default:    ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Next-state logic for seg/min/hora: BCD advance on tick with carry and the
// 12-hour/PM rule; a bus write to a register overrides its advanced value.
module bcd_time_counter
  import rtc_bus_pkg::*;
(
  input  logic       tick_i,
  input  logic [7:0] seg_i,
  input  logic [7:0] min_i,
  input  logic [7:0] hora_i,
  input  logic       wr_seg_i,
  input  logic       wr_min_i,
  input  logic       wr_hora_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] seg_o,
  output logic [7:0] min_o,
  output logic [7:0] hora_o
);

  logic       seg_carry;
  logic       min_carry;
  logic [7:0] seg_adv;
  logic [7:0] min_adv;
  logic [7:0] hora_adv;

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    seg_adv   = seg_i;
    min_adv   = min_i;
    hora_adv  = hora_i;
    seg_carry = tick_i && (seg_i == BCD_SEC_MAX);
    min_carry = seg_carry && (min_i == BCD_SEC_MAX);

    if (tick_i)    seg_adv = seg_carry ? 8'h00 : bcd_inc(seg_i);
    if (seg_carry) min_adv = min_carry ? 8'h00 : bcd_inc(min_i);

    // 12 -> 01 keeps the PM flag; 11 -> 12 is where AM/PM flips.
    if (min_carry) begin
      if (hora_i[6:0] == BCD_HOUR_MAX[6:0])
        hora_adv = {hora_i[7], 7'h01};
      else if (hora_i[6:0] == 7'h11)
        hora_adv = {~hora_i[7], BCD_HOUR_MAX[6:0]};
      else
        hora_adv = bcd_inc({1'b0, hora_i[6:0]}) | {hora_i[7], 7'h00};
    end

    seg_o  = wr_seg_i  ? wr_data_i : seg_adv;
    min_o  = wr_min_i  ? wr_data_i : min_adv;
    hora_o = wr_hora_i ? wr_data_i : hora_adv;
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// Chip-side responder for the multiplexed RTC bus: register file with a
// read-side snapshot, BCD time-of-day advance on tick, and a strobe FSM.
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter bit          TICK_EN = 1'b1,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ad,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] ADin,
  input  logic       tick,
  output logic [7:0] ADout,
  output logic       oe
);

  localparam logic [2:0] RD_LAT_W = 3'(RD_LAT);

  logic       cs_q, ad_q, wr_q, rd_q, wr_prev_q;
  logic [7:0] adin_q;
  logic       wr_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cs_q      <= 1'b1;
      ad_q      <= 1'b0;
      wr_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_prev_q <= 1'b1;
      adin_q    <= 8'h00;
    end else begin
      cs_q      <= cs;
      ad_q      <= ad;
      wr_q      <= wr;
      rd_q      <= rd;
      wr_prev_q <= wr_q;
      adin_q    <= ADin;
    end
  end

  assign wr_rise = wr_q && !wr_prev_q;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] adout_q, adout_d;
  logic       oe_q, oe_d;
  logic       wr_en;
  logic       snap;
  logic       load_rd;
  rtc_regs_t  regs_q, regs_d;
  rtc_regs_t  shadow_q, shadow_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    adout_d  = adout_q;
    oe_d     = oe_q;
    wr_en    = 1'b0;
    snap     = 1'b0;
    load_rd  = 1'b0;

    if (!wr_q && !rd_q) begin
      state_d = ST_IDLE;
      adout_d = BUS_IDLE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!cs_q && !wr_q) begin
            state_d = ad_q ? ST_WRDATA : ST_ADDR;
          end else if (!cs_q && ad_q && !rd_q) begin
            state_d  = ST_RDDATA;
            rd_cnt_d = 3'd1;
            load_rd  = (RD_LAT_W == 3'd1);
          end
        end
        ST_ADDR: begin
          if (cs_q) begin
            state_d = ST_IDLE;
          end else if (wr_rise) begin
            addr_d  = adin_q;
            snap    = (adin_q == ADDR_CMD);
            state_d = ST_IDLE;
          end
        end
        ST_WRDATA: begin
          if (cs_q) begin
            state_d = ST_IDLE;
          end else if (wr_rise) begin
            wr_en   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_RDDATA: begin
          if (cs_q || rd_q) begin
            state_d = ST_IDLE;
            adout_d = BUS_IDLE;
            oe_d    = 1'b0;
          end else if (!oe_q) begin
            rd_cnt_d = rd_cnt_q + 3'd1;
            load_rd  = (rd_cnt_d == RD_LAT_W);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Read data is captured once and held, so a tick mid-read cannot glitch it.
    if (load_rd) begin
      adout_d = reg_read(shadow_q, addr_q);
      oe_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= RST_ADDR;
      rd_cnt_q <= 3'd0;
      adout_q  <= BUS_IDLE;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_cnt_q <= rd_cnt_d;
      adout_q  <= adout_d;
      oe_q     <= oe_d;
    end
  end

  logic [7:0] seg_next, min_next, hora_next;

  bcd_time_counter u_time (
    .tick_i    (tick && TICK_EN),
    .seg_i     (regs_q.seg),
    .min_i     (regs_q.min),
    .hora_i    (regs_q.hora),
    .wr_seg_i  (wr_en && (addr_q == ADDR_SEG)),
    .wr_min_i  (wr_en && (addr_q == ADDR_MIN)),
    .wr_hora_i (wr_en && (addr_q == ADDR_HORA)),
    .wr_data_i (adin_q),
    .seg_o     (seg_next),
    .min_o     (min_next),
    .hora_o    (hora_next)
  );

  // Writes land in both copies so readback is immediate; the snapshot copies
  // the live set as it stood before this cycle's tick.
  always_comb begin
    regs_d   = regs_q;
    shadow_d = shadow_q;
    if (snap) shadow_d = regs_q;
    if (wr_en) begin
      regs_d   = reg_write(regs_q, addr_q, adin_q);
      shadow_d = reg_write(shadow_q, addr_q, adin_q);
    end
    regs_d.seg  = seg_next;
    regs_d.min  = min_next;
    regs_d.hora = hora_next;
  end

  // NOTE: the register file is nine flop bytes with defined power-on values,
  // so it takes the async reset like any other state; it is not a RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q   <= REGS_RST;
      shadow_q <= REGS_RST;
    end else begin
      regs_q   <= regs_d;
      shadow_q <= shadow_d;
    end
  end

  assign ADout = adout_q;
  assign oe    = oe_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder: bus tasks push expected oe events into
// a scoreboard queue; a negedge monitor pops and compares on every oe change.
module tb_rtc_bus_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ad    = 1'b0;
  logic       cs    = 1'b1;
  logic       wr    = 1'b1;
  logic       rd    = 1'b1;
  logic       tick  = 1'b0;
  logic [7:0] ADin  = 8'h00;
  logic [7:0] ADout;
  logic       oe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic       oe;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  rtc_bus_responder dut (
    .clock (clock),
    .reset (reset),
    .ad    (ad),
    .cs    (cs),
    .wr    (wr),
    .rd    (rd),
    .ADin  (ADin),
    .tick  (tick),
    .ADout (ADout),
    .oe    (oe)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp(input logic e_oe, input logic [7:0] e_data, input int e_cyc);
    exp_t e;
    e.oe   = e_oe;
    e.data = e_data;
    e.cyc  = e_cyc;
    exp_q.push_back(e);
  endtask

  task automatic bus_addr(input logic [7:0] a);
    cs = 1'b0; ad = 1'b0; ADin = a; wr = 1'b0;
    step(2);
    wr = 1'b1;
    step(2);
    cs = 1'b1;
    step(2);
  endtask

  task automatic bus_write(input logic [7:0] d, input bit with_tick);
    cs = 1'b0; ad = 1'b1; ADin = d; wr = 1'b0;
    step(2);
    wr = 1'b1;
    step(1);
    if (with_tick) tick = 1'b1;
    step(1);
    tick = 1'b0;
    cs   = 1'b1;
    step(2);
  endtask

  // Data valid 2 cycles after rd falls; released 2 cycles after rd/cs rise.
  task automatic bus_read(input logic [7:0] exp);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    push_exp(1'b1, exp, cyc + 2);
    step(4);
    rd = 1'b1; cs = 1'b1;
    push_exp(1'b0, 8'hFF, cyc + 2);
    step(3);
  endtask

  task automatic wreg(input logic [7:0] a, input logic [7:0] d);
    bus_addr(a);
    bus_write(d, 1'b0);
  endtask

  task automatic rreg(input logic [7:0] a, input logic [7:0] exp);
    bus_addr(a);
    bus_read(exp);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
  endtask

  initial begin : monitor
    logic oe_prev;
    exp_t e;
    oe_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        oe_prev = 1'b0;
      end else if (oe !== oe_prev) begin
        oe_prev = oe;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL oe_unexpected: got oe=%0b ADout=%0h expected no bus event (cycle %0d)",
                   oe, ADout, cyc);
        end else begin
          e = exp_q.pop_front();
          check("sb_oe_level", {31'd0, oe}, {31'd0, e.oe});
          check("sb_adout", {24'd0, ADout}, {24'd0, e.data});
          check("sb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2 reset = 1'b0;
    step(3);
    check("reset_adout", {24'd0, ADout}, 32'hFF);
    check("reset_oe", {31'd0, oe}, 32'd0);
    reset = 1'b1;
    step(2);

    // Write/readback
    wreg(8'h22, 8'h47);
    rreg(8'h22, 8'h47);

    // Reset mid-read: outputs drop immediately, registers return to reset values
    bus_addr(8'h22);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    push_exp(1'b1, 8'h47, cyc + 2);
    step(3);
    reset = 1'b0;
    #1;
    check("midrst_adout", {24'd0, ADout}, 32'hFF);
    check("midrst_oe", {31'd0, oe}, 32'd0);
    step(2);
    rd = 1'b1; cs = 1'b1;
    step(1);
    reset = 1'b1;
    step(2);
    rreg(8'h23, 8'h12);
    rreg(8'h24, 8'h01);
    rreg(8'h22, 8'h00);

    // Hour rollover 11:59:59 AM -> 12:00:00 PM, then 12:59:59 PM -> 01:00:00 PM
    wreg(8'h21, 8'h59);
    wreg(8'h22, 8'h59);
    wreg(8'h23, 8'h11);
    pulse_tick();
    bus_addr(8'hF0);
    rreg(8'h21, 8'h00);
    rreg(8'h22, 8'h00);
    rreg(8'h23, 8'h92);
    bus_addr(8'hF0);
    bus_read(8'h00);
    wreg(8'h21, 8'h59);
    wreg(8'h22, 8'h59);
    wreg(8'h23, 8'h92);
    pulse_tick();
    bus_addr(8'hF0);
    rreg(8'h23, 8'h81);
    rreg(8'h21, 8'h00);

    // Snapshot holds the frame while live time advances
    wreg(8'h21, 8'h10);
    bus_addr(8'hF0);
    repeat (3) pulse_tick();
    rreg(8'h21, 8'h10);
    bus_addr(8'hF0);
    rreg(8'h21, 8'h13);

    // Write to seg in the same cycle as a tick with seg=59
    wreg(8'h21, 8'h59);
    wreg(8'h22, 8'h05);
    bus_addr(8'h21);
    bus_write(8'h30, 1'b1);
    bus_addr(8'hF0);
    rreg(8'h21, 8'h30);
    rreg(8'h22, 8'h06);
    rreg(8'h23, 8'h81);

    // Aborted write: cs rises before wr does
    bus_addr(8'h21);
    cs = 1'b0; ad = 1'b1; ADin = 8'h77; wr = 1'b0;
    step(2);
    cs = 1'b1;
    step(1);
    wr = 1'b1;
    step(3);

    // wr and rd low together
    bus_addr(8'h21);
    cs = 1'b0; ad = 1'b1; ADin = 8'h44; wr = 1'b0; rd = 1'b0;
    step(3);
    wr = 1'b1; rd = 1'b1; cs = 1'b1;
    step(3);
    bus_addr(8'hF0);
    rreg(8'h21, 8'h30);

    // Unmapped read, crono and date are plain storage
    rreg(8'h55, 8'hFF);
    wreg(8'h42, 8'h33);
    wreg(8'h24, 8'h15);
    pulse_tick();
    bus_addr(8'hF0);
    rreg(8'h42, 8'h33);
    rreg(8'h24, 8'h15);
    rreg(8'h21, 8'h31);

    step(5);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
